// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with a one-entry skid buffer, write-back mux,
// forwarding taps and a committed register-write counter.
module mem_wb_pipe #(
    parameter int DATA_W    = 32,
    parameter int RA_W      = 5,
    parameter int CNT_W     = 16,
    parameter int ZERO_KILL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [RA_W-1:0]   rd_addr_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [RA_W-1:0]   rd_addr_out,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [RA_W-1:0]   fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  wb_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    logic [DATA_W-1:0] m_rdata, m_alu, s_rdata, s_alu;
    logic [RA_W-1:0]   m_rd, s_rd;
    logic              m_rw, m_m2r, s_rw, s_m2r;
    logic              accept, pop, cap_rw;

    assign in_ready  = !rst && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Writes to r0 are architecturally dead, so drop the write enable at capture.
    assign cap_rw = reg_write_in && !((ZERO_KILL != 0) && (rd_addr_in == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            m_rdata  <= '0;
            m_alu    <= '0;
            m_rd     <= '0;
            m_rw     <= 1'b0;
            m_m2r    <= 1'b0;
            s_rdata  <= '0;
            s_alu    <= '0;
            s_rd     <= '0;
            s_rw     <= 1'b0;
            s_m2r    <= 1'b0;
            wb_count <= '0;
        end else begin
            // A pop completes even when flush lands in the same cycle.
            if (pop && m_rw)
                wb_count <= wb_count + CNT_W'(1);

            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            m_rdata <= read_data_in;
                            m_alu   <= alu_res_in;
                            m_rd    <= rd_addr_in;
                            m_rw    <= cap_rw;
                            m_m2r   <= mem_to_reg_in;
                            state   <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            m_rdata <= read_data_in;
                            m_alu   <= alu_res_in;
                            m_rd    <= rd_addr_in;
                            m_rw    <= cap_rw;
                            m_m2r   <= mem_to_reg_in;
                        end else if (accept) begin
                            s_rdata <= read_data_in;
                            s_alu   <= alu_res_in;
                            s_rd    <= rd_addr_in;
                            s_rw    <= cap_rw;
                            s_m2r   <= mem_to_reg_in;
                            state   <= TWO;
                        end else if (pop) begin
                            state <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            m_rdata <= s_rdata;
                            m_alu   <= s_alu;
                            m_rd    <= s_rd;
                            m_rw    <= s_rw;
                            m_m2r   <= s_m2r;
                            state   <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign read_data_out  = m_rdata;
    assign alu_res_out    = m_alu;
    assign rd_addr_out    = m_rd;
    assign reg_write_out  = m_rw;
    assign mem_to_reg_out = m_m2r;
    assign wb_data        = m_m2r ? m_rdata : m_alu;
    assign fwd_valid      = out_valid && m_rw;
    assign fwd_addr       = m_rd;
    assign fwd_data       = wb_data;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_mem_wb_pipe;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
    } ent_t;

    logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] read_data_in, alu_res_in, read_data_out, alu_res_out, wb_data, fwd_data;
    logic [4:0]  rd_addr_in, rd_addr_out, fwd_addr;
    logic        reg_write_in, mem_to_reg_in, reg_write_out, mem_to_reg_out, fwd_valid;
    logic [3:0]  wb_count;

    int total = 0;
    int bad   = 0;

    ent_t        q[$];
    ent_t        shown;
    int unsigned mcount;

    mem_wb_pipe #(.DATA_W(32), .RA_W(5), .CNT_W(4), .ZERO_KILL(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .read_data_in(read_data_in), .alu_res_in(alu_res_in), .rd_addr_in(rd_addr_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .read_data_out(read_data_out), .alu_res_out(alu_res_out), .rd_addr_out(rd_addr_out),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .wb_count(wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t mk(input logic [31:0] rdata, input logic [31:0] alu,
                                input logic [4:0] rd, input logic rw, input logic m2r);
        ent_t e;
        e.rdata = rdata; e.alu = alu; e.rd = rd; e.rw = rw; e.m2r = m2r;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        return mk($urandom, $urandom, 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    endfunction

    // One clock: drive inputs, advance the reference queue, sample 1 time unit after the edge.
    task automatic cycle(input logic r, input logic v, input logic f, input logic ord, input ent_t e);
        logic acc, pp;
        ent_t s;
        rst = r; in_valid = v; flush = f; out_ready = ord;
        read_data_in = e.rdata; alu_res_in = e.alu; rd_addr_in = e.rd;
        reg_write_in = e.rw; mem_to_reg_in = e.m2r;
        acc = !r && v && (q.size() < 2);
        pp  = (q.size() > 0) && ord;
        @(posedge clk);
        if (r) begin
            q.delete();
            shown  = mk('0, '0, '0, 1'b0, 1'b0);
            mcount = 0;
        end else begin
            if (pp) begin
                if (q[0].rw) mcount = (mcount + 1) % 16;
                void'(q.pop_front());
            end
            if (f) q.delete();
            else if (acc) begin
                s = e;
                if (e.rd == 5'd0) s.rw = 1'b0;
                q.push_back(s);
            end
            if (q.size() > 0) shown = q[0];
        end
        #1;
    endtask

    task automatic test_reset();
        ent_t e;
        e = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 5'd7, 1'b1, 1'b1);
        cycle(1, 1, 0, 1, e);
        cycle(1, 1, 0, 1, e);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if ({read_data_out, alu_res_out, rd_addr_out, reg_write_out, mem_to_reg_out} !== '0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h/%b/%b want=0", read_data_out, alu_res_out, rd_addr_out, reg_write_out, mem_to_reg_out);
        end
        total++; if ({wb_data, fwd_valid, fwd_addr, fwd_data} !== '0) begin
            bad++; $display("FAIL reset_fwd got=%h/%b/%h/%h want=0", wb_data, fwd_valid, fwd_addr, fwd_data);
        end
        total++; if (wb_count !== 4'd0) begin bad++; $display("FAIL reset_wb_count got=%0d want=0", wb_count); end
        cycle(0, 0, 0, 1, e);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_backpressure();
        ent_t a, b, c;
        a = mk(32'h0, 32'h11111111, 5'd3, 1'b1, 1'b0);
        b = mk(32'h0, 32'h22222222, 5'd4, 1'b1, 1'b0);
        c = mk(32'h0, 32'h33333333, 5'd5, 1'b1, 1'b0);
        cycle(0, 1, 0, 0, a);
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_a got=%b/%b want=1/1", out_valid, in_ready); end
        cycle(0, 1, 0, 0, b);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b want=0", in_ready); end
        cycle(0, 1, 0, 0, c);
        total++; if (in_ready !== 1'b0 || alu_res_out !== 32'h11111111) begin
            bad++; $display("FAIL bp_hold got=%b/%h want=0/11111111", in_ready, alu_res_out);
        end
        cycle(0, 1, 0, 1, c);
        total++; if (alu_res_out !== 32'h22222222 || rd_addr_out !== 5'd4) begin bad++; $display("FAIL bp_head_b got=%h/%0d want=22222222/4", alu_res_out, rd_addr_out); end
        cycle(0, 1, 0, 1, c);
        total++; if (alu_res_out !== 32'h33333333 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_head_c got=%h/%b want=33333333/1", alu_res_out, out_valid); end
        cycle(0, 0, 0, 1, c);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", out_valid); end
        total++; if (wb_count !== 4'd3) begin bad++; $display("FAIL bp_wb_count got=%0d want=3", wb_count); end
    endtask

    task automatic test_stream();
        ent_t e;
        logic [31:0] want;
        for (int i = 0; i < 8; i++) begin
            e = mk($urandom, $urandom, 5'($urandom_range(1, 31)), 1'($urandom), 1'(i % 2));
            want = e.m2r ? e.rdata : e.alu;
            cycle(0, 1, 0, 1, e);
            total++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL stream_hs[%0d] got=%b/%b want=1/1", i, in_ready, out_valid); end
            total++; if (alu_res_out !== e.alu || wb_data !== want) begin
                bad++; $display("FAIL stream_data[%0d] got=%h/%h want=%h/%h", i, alu_res_out, wb_data, e.alu, want);
            end
        end
        cycle(0, 0, 0, 1, e);
        total++; if (wb_count !== 4'(mcount)) begin bad++; $display("FAIL stream_wb_count got=%0d want=%0d", wb_count, mcount); end
    endtask

    task automatic test_flush();
        ent_t x, y, z, w;
        int unsigned c0;
        x = mk(32'h0, 32'hAAAA0001, 5'd5, 1'b1, 1'b0);
        y = mk(32'h0, 32'hBBBB0002, 5'd6, 1'b1, 1'b0);
        z = mk(32'h0, 32'hCCCC0003, 5'd7, 1'b1, 1'b0);
        w = mk(32'h0, 32'hDDDD0004, 5'd8, 1'b1, 1'b0);
        cycle(0, 1, 0, 0, x);
        cycle(0, 1, 0, 0, y);
        c0 = mcount;
        cycle(0, 1, 1, 1, z);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_state got=%b/%b want=0/1", out_valid, in_ready); end
        total++; if (wb_count !== 4'((c0 + 1) % 16)) begin bad++; $display("FAIL flush_wb_count got=%0d want=%0d", wb_count, (c0 + 1) % 16); end
        cycle(0, 0, 0, 1, z);
        cycle(0, 0, 0, 1, z);
        total++; if (out_valid !== 1'b0 || alu_res_out !== 32'hAAAA0001) begin
            bad++; $display("FAIL flush_hold got=%b/%h want=0/aaaa0001", out_valid, alu_res_out);
        end
        cycle(0, 1, 0, 0, w);
        total++; if (out_valid !== 1'b1 || alu_res_out !== 32'hDDDD0004) begin
            bad++; $display("FAIL flush_next got=%b/%h want=1/dddd0004", out_valid, alu_res_out);
        end
        cycle(0, 0, 0, 1, w);
    endtask

    task automatic test_zero_kill();
        ent_t k;
        int unsigned c0;
        k = mk(32'h12345678, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0);
        c0 = mcount;
        cycle(0, 1, 0, 0, k);
        total++; if (reg_write_out !== 1'b0 || fwd_valid !== 1'b0) begin bad++; $display("FAIL zk_rw got=%b/%b want=0/0", reg_write_out, fwd_valid); end
        total++; if (alu_res_out !== 32'hDEADBEEF || read_data_out !== 32'h12345678) begin
            bad++; $display("FAIL zk_data got=%h/%h want=deadbeef/12345678", alu_res_out, read_data_out);
        end
        cycle(0, 0, 0, 1, k);
        total++; if (out_valid !== 1'b0 || wb_count !== 4'(c0)) begin bad++; $display("FAIL zk_count got=%b/%0d want=0/%0d", out_valid, wb_count, c0); end
    endtask

    task automatic test_reset_midop();
        ent_t e;
        e = mk(32'h0, 32'h0BADF00D, 5'd9, 1'b1, 1'b0);
        cycle(0, 1, 0, 0, e);
        cycle(0, 1, 0, 0, e);
        cycle(1, 1, 0, 1, e);
        total++; if (out_valid !== 1'b0 || wb_count !== 4'd0 || alu_res_out !== 32'h0) begin
            bad++; $display("FAIL midrst got=%b/%0d/%h want=0/0/0", out_valid, wb_count, alu_res_out);
        end
        cycle(0, 0, 0, 1, e);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL midrst_release got=%b/%b want=0/1", out_valid, in_ready); end
    endtask

    task automatic test_wrap();
        ent_t e;
        cycle(1, 0, 0, 0, e);
        for (int i = 0; i < 17; i++) begin
            e = mk($urandom, $urandom, 5'($urandom_range(1, 31)), 1'b1, 1'($urandom));
            cycle(0, 1, 0, 1, e);
        end
        cycle(0, 0, 0, 1, e);
        total++; if (wb_count !== 4'd1) begin bad++; $display("FAIL wrap_wb_count got=%0d want=1", wb_count); end
    endtask

    task automatic test_random();
        ent_t e;
        logic r;
        logic [31:0] wd;
        for (int i = 0; i < 400; i++) begin
            e = rnd_ent();
            r = ($urandom_range(0, 99) < 2);
            cycle(r, 1'($urandom), ($urandom_range(0, 99) < 6), ($urandom_range(0, 3) != 0), e);
            wd = shown.m2r ? shown.rdata : shown.alu;
            total++; if (out_valid !== (q.size() > 0) || in_ready !== (!r && q.size() < 2)) begin
                bad++; $display("FAIL rnd_hs[%0d] got=%b/%b want=%b/%b", i, out_valid, in_ready, q.size() > 0, !r && q.size() < 2);
            end
            total++; if (read_data_out !== shown.rdata || alu_res_out !== shown.alu || rd_addr_out !== shown.rd
                         || reg_write_out !== shown.rw || mem_to_reg_out !== shown.m2r) begin
                bad++; $display("FAIL rnd_head[%0d] got=%h/%h/%0d/%b/%b want=%h/%h/%0d/%b/%b", i, read_data_out, alu_res_out,
                                rd_addr_out, reg_write_out, mem_to_reg_out, shown.rdata, shown.alu, shown.rd, shown.rw, shown.m2r);
            end
            total++; if (wb_data !== wd || fwd_data !== wd || fwd_addr !== shown.rd || fwd_valid !== ((q.size() > 0) && shown.rw)) begin
                bad++; $display("FAIL rnd_fwd[%0d] got=%h/%h/%0d/%b want=%h/%h/%0d/%b", i, wb_data, fwd_data, fwd_addr, fwd_valid,
                                wd, wd, shown.rd, (q.size() > 0) && shown.rw);
            end
            total++; if (wb_count !== 4'(mcount)) begin bad++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", i, wb_count, mcount); end
        end
    endtask

    initial begin
        q.delete();
        shown  = mk('0, '0, '0, 1'b0, 1'b0);
        mcount = 0;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        read_data_in = '0; alu_res_in = '0; rd_addr_in = '0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
        test_reset();
        test_backpressure();
        test_stream();
        test_flush();
        test_zero_kill();
        test_reset_midop();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of read-data, ALU-result and write-back data.
REQ-002 SHALL have parameter RA_W, default 5, width of destination register address.
REQ-003 SHALL have parameter CNT_W, default 16, width of write-back counter.
REQ-004 SHALL have parameter ZERO_KILL, default 1; when 1, writes to register 0 are suppressed.
REQ-005 SHALL have one clock and a synchronous, active-high reset, as in the ports below.
REQ-006 SHALL have these ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  MEM stage offers an entry
- in_ready  out  1  entry can be accepted
- flush  in  1  discard all held entries
- read_data_in  in  DATA_W  memory read data
- alu_res_in  in  DATA_W  ALU result / address
- rd_addr_in  in  RA_W  destination register
- reg_write_in  in  1  register-write control
- mem_to_reg_in  in  1  write-back source select
- out_valid  out  1  head entry valid
- out_ready  in  1  WB stage consumes head
- read_data_out  out  DATA_W  head read data
- alu_res_out  out  DATA_W  head ALU result
- rd_addr_out  out  RA_W  head destination
- reg_write_out  out  1  head register write
- mem_to_reg_out  out  1  head source select
- wb_data  out  DATA_W  mem_to_reg_out ? read_data_out : alu_res_out
- fwd_valid  out  1  out_valid & reg_write_out
- fwd_addr  out  RA_W  equals rd_addr_out
- fwd_data  out  DATA_W  equals wb_data
- wb_count  out  CNT_W  committed register writes

Function
REQ-007 SHALL hold up to two entries: a main register (drives outputs) and a skid register.
REQ-008 SHALL implement states EMPTY (0 entries), ONE (main valid), TWO (main and skid valid).
REQ-009 in_ready SHALL equal !rst & (state != TWO); accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-010 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-011 EMPTY: accept -> ONE, main loaded; else stay.
REQ-012 ONE: accept & pop -> ONE, main loaded; accept & !pop -> TWO, skid loaded; pop & !accept -> EMPTY; neither -> stay.
REQ-013 TWO: pop -> ONE, main loaded from skid; else stay; no accept possible.
REQ-014 Latency SHALL be 1 cycle from accept to out_valid when empty or popping; full throughput 1 entry/cycle with out_ready=1.
REQ-015 Entries SHALL leave in acceptance order; no entry is lost or duplicated.
REQ-016 On capture, when ZERO_KILL=1 and rd_addr_in=0, stored reg_write SHALL be 0; other fields stored unchanged.
REQ-017 flush SHALL force EMPTY next cycle, discard any same-cycle accept, and not alter data registers.
REQ-018 A pop in the flush cycle SHALL still count as completed for wb_count.
REQ-019 wb_count SHALL increment by 1 on each pop with reg_write_out=1, wrapping modulo 2^CNT_W; flush does not clear it.
REQ-020 Data output registers SHALL hold last value when out_valid=0.
REQ-021 wb_data, fwd_* SHALL be combinational from the main register only.

Reset
REQ-022 rst SHALL take priority over flush and all handshakes.
REQ-023 On rst: state EMPTY, all data/control registers (main and skid) 0, wb_count 0, in_ready 0 while rst high, 1 the first cycle after deassertion.
REQ-024 rst mid-operation SHALL discard both entries without a pop being counted.

Verification
REQ-025 Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, wb_count=0; cycle after release in_ready=1.
REQ-026 Backpressure: out_ready=0, push A(alu 0x11111111, rd 3, rw 1), B(alu 0x22222222, rd 4, rw 1) -> in_ready=0 after B, C held off; then out_ready=1 -> A, B, C one per cycle, wb_count=3.
REQ-027 Streaming: in_valid=out_ready=1 for 8 entries -> each appears 1 cycle later, in_ready constant 1, wb_data = read_data when mem_to_reg=1 else alu_res.
REQ-028 Flush in TWO with out_ready=1, head rw=1 -> next cycle out_valid=0, in_ready=1, wb_count +1; skid entry never appears.
REQ-029 ZERO_KILL=1: push rd 0, rw 1, alu 0xDEADBEEF -> reg_write_out=0, fwd_valid=0, wb_count unchanged, alu_res_out=0xDEADBEEF.
REQ-030 CNT_W=4: 17 popped entries with rw=1 -> wb_count=1.
